// File: rtl/regfile_dump_reader.sv
// Debug readout engine: walks a window of the register file through a spare
// combinational read port and streams (address, data) words over valid/ready.
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW-1:0] dout_addr,
  output logic [DW-1:0] dout_data,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [AW:0]   remaining, remaining_n;
  logic          dout_valid_n, dout_last_n, busy_n, done_n;
  logic [AW-1:0] dout_addr_n;
  logic [DW-1:0] dout_data_n;
  logic          handshake, load;

  // Requests larger than the register file dump it once, never twice.
  function automatic logic [AW:0] sat_count(input logic [AW:0] c);
    if (c > (AW+1)'(NREGS)) return (AW+1)'(NREGS);
    return c;
  endfunction

  assign rd_addr   = ptr;
  assign handshake = dout_valid & dout_ready;
  assign load      = (remaining != '0) && (!dout_valid || dout_ready);

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    remaining_n  = remaining;
    dout_valid_n = dout_valid;
    dout_addr_n  = dout_addr;
    dout_data_n  = dout_data;
    dout_last_n  = dout_last;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort && (count != '0)) begin
          state_n     = RUN;
          ptr_n       = start_addr;
          remaining_n = sat_count(count);
        end
      end
      RUN: begin
        if (abort) begin
          // Abort drops any in-flight word, even one being accepted now.
          state_n      = IDLE;
          dout_valid_n = 1'b0;
          dout_last_n  = 1'b0;
          remaining_n  = '0;
        end else if (handshake && dout_last) begin
          state_n      = IDLE;
          dout_valid_n = 1'b0;
          dout_last_n  = 1'b0;
          done_n       = 1'b1;
        end else if (load) begin
          dout_data_n  = rd_data;
          dout_addr_n  = ptr;
          dout_last_n  = (remaining == (AW+1)'(1));
          dout_valid_n = 1'b1;
          ptr_n        = ptr + AW'(1);
          remaining_n  = remaining - (AW+1)'(1);
        end else if (handshake) begin
          dout_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
  end

  // Registered output / control stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      dout_valid <= 1'b0;
      dout_addr  <= '0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      remaining  <= remaining_n;
      dout_valid <= dout_valid_n;
      dout_addr  <= dout_addr_n;
      dout_data  <= dout_data_n;
      dout_last  <= dout_last_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file
// whose x0 always reads zero.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  count;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  dout_addr;
  logic [31:0] dout_data;
  logic        dout_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [4:0]  hs_addr [64];
  logic [31:0] hs_data [64];
  logic        hs_last [64];
  int          n_hs;
  int          n_done;

  regfile_dump_reader #(.NREGS(32), .AW(5), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_addr  (dout_addr),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

  function automatic logic [31:0] exp_reg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a dump and plays a consumer with ready pattern pat (bit i = cycle i
  // after the start edge); records handshakes and checks stall stability.
  task automatic run_dump(input logic [4:0] sa, input logic [5:0] cnt, input logic [63:0] pat);
    logic        pv, pr, pl;
    logic [4:0]  pa;
    logic [31:0] pd;
    n_hs = 0; n_done = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pd = '0;
    start = 1'b1; start_addr = sa; count = cnt; dout_ready = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      dout_ready = pat[i % 64];
      if (pv && !pr) begin
        chk("hold_valid", dout_valid, 1'b1);
        chk("hold_addr", dout_addr, pa);
        chk("hold_data", dout_data, pd);
        chk("hold_last", dout_last, pl);
      end
      if (dout_valid && dout_ready && n_hs < 64) begin
        hs_addr[n_hs] = dout_addr;
        hs_data[n_hs] = dout_data;
        hs_last[n_hs] = dout_last;
        n_hs++;
      end
      pv = dout_valid; pr = dout_ready; pa = dout_addr; pd = dout_data; pl = dout_last;
      tick;
      if (done) begin
        n_done++;
        chk("busy_at_done", busy, 1'b0);
        chk("valid_at_done", dout_valid, 1'b0);
        break;
      end
    end
    dout_ready = 1'b1;
    tick;
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic check_window(input string tag, input logic [4:0] sa, input int n);
    logic [4:0] a;
    chk({tag, "_nhs"}, n_hs, n);
    chk({tag, "_ndone"}, n_done, 1);
    for (int k = 0; k < n && k < n_hs; k++) begin
      a = sa + 5'(k);
      chk({tag, "_addr"}, hs_addr[k], a);
      chk({tag, "_data"}, hs_data[k], exp_reg(a));
      chk({tag, "_last"}, hs_last[k], (k == n - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
    regs[0] = 32'hDEAD_BEEF;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; abort = 1'b0; dout_ready = 1'b0;
    tick; tick;
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    chk("rst_dout", {dout_addr, dout_data, dout_last}, '0);
    rst_n = 1'b1;
    tick;

    // Basic dump, consumer always ready
    regs[5] = 32'hAAAA_0005; regs[6] = 32'h1234_5678; regs[7] = 32'hFFFF_FFFF;
    tick;
    start = 1'b1; start_addr = 5'd5; count = 6'd3; dout_ready = 1'b1;
    tick;
    start = 1'b0;
    chk("b_busy0", busy, 1'b1);
    chk("b_valid0", dout_valid, 1'b0);
    chk("b_rd_addr", rd_addr, 5'd5);
    tick;
    chk("b_w0", {dout_valid, dout_last, dout_addr, dout_data}, {1'b1, 1'b0, 5'd5, 32'hAAAA_0005});
    tick;
    chk("b_w1", {dout_valid, dout_last, dout_addr, dout_data}, {1'b1, 1'b0, 5'd6, 32'h1234_5678});
    tick;
    chk("b_w2", {dout_valid, dout_last, dout_addr, dout_data}, {1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF});
    chk("b_busy_w2", busy, 1'b1);
    chk("b_done_w2", done, 1'b0);
    tick;
    chk("b_end", {dout_valid, dout_last, busy, done}, 4'b0001);
    tick;
    chk("b_done_low", done, 1'b0);

    // Backpressure: ready 0,0,1,0,1,1
    run_dump(5'd5, 6'd3, {{58{1'b1}}, 6'b110100});
    check_window("bp", 5'd5, 3);

    // Wrap-around through x0
    run_dump(5'd30, 6'd4, '1);
    check_window("wrap", 5'd30, 4);

    // Full dump, then clamped oversize request
    run_dump(5'd0, 6'd32, '1);
    check_window("full", 5'd0, 32);
    run_dump(5'd0, 6'd40, '1);
    check_window("clamp", 5'd0, 32);

    // Start while busy, then abort after two handshakes
    start = 1'b1; start_addr = 5'd10; count = 6'd10; dout_ready = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("ab_w0", dout_addr, 5'd10);
    start = 1'b1; start_addr = 5'd0; count = 6'd5;
    tick;
    start = 1'b0;
    chk("ab_busy_start", {dout_valid, dout_addr}, {1'b1, 5'd11});
    tick;
    chk("ab_w2", {dout_valid, dout_addr}, {1'b1, 5'd12});
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_stop", {dout_valid, dout_last, busy, done}, 4'b0000);
    tick;
    chk("ab_no_done", {dout_valid, busy, done}, 3'b000);

    // count==0 and abort-with-start are both ignored in IDLE
    start = 1'b1; start_addr = 5'd3; count = 6'd0;
    tick;
    start = 1'b0;
    chk("c0_idle", {dout_valid, busy, done}, 3'b000);
    tick;
    chk("c0_quiet", {dout_valid, busy, done}, 3'b000);
    start = 1'b1; abort = 1'b1; count = 6'd3;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("ab_wins", busy, 1'b0);
    tick;
    chk("ab_wins_quiet", {dout_valid, done}, 2'b00);

    // Asynchronous reset while stalled
    start = 1'b1; start_addr = 5'd20; count = 6'd3; dout_ready = 1'b0;
    tick;
    start = 1'b0;
    tick;
    chk("mr_pre_valid", {dout_valid, dout_addr}, {1'b1, 5'd20});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_outs", {dout_valid, dout_last, busy, done, dout_addr, dout_data}, '0);
    chk("mr_rd_addr", rd_addr, 5'd0);
    tick;
    rst_n = 1'b1;
    tick;
    run_dump(5'd5, 6'd3, '1);
    check_window("mr_fresh", 5'd5, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
